// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_MASTERS masters share one slave port.
// The grant is held for a master's whole cyc; a silent slave is cut off with err after TIMEOUT cycles.

module wb_rr_arb_port (
  input  logic sel_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic to_i,
  output logic ack_o,
  output logic err_o
);
  // A pending timeout overrides whatever the slave reports in that cycle.
  assign ack_o = sel_i & stb_i & ack_i & ~to_i;
  assign err_o = sel_i & (to_i | (stb_i & err_i));
endmodule

module wb_rr_arbiter #(
  parameter  int NUM_MASTERS = 4,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  parameter  int TIMEOUT     = 255,
  localparam int SEL_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_dat_r,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_dat_w,
  output logic [SEL_WIDTH-1:0]              s_sel,
  input  logic                              s_ack,
  input  logic                              s_err,
  input  logic [DATA_WIDTH-1:0]             s_dat_r,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              timeout_pulse,
  output logic [7:0]                        timeout_count
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, OWN} state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic [SEL_WIDTH-1:0]  sel;
  } wb_req_t;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          gidx_q;
  logic [IW-1:0]          last_q;
  logic [IW-1:0]          win;
  logic [NUM_MASTERS-1:0] win_oh;
  logic                   own;
  logic                   to_pend;
  wb_req_t                req_sel;

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    int cand;
    cand = 0;
    win  = last_q;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (m_cyc[IW'(cand)]) win = IW'(cand);
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        IDLE: if (|m_cyc) begin
          state_q <= OWN;
          grant_q <= win_oh;
          gidx_q  <= win;
          last_q  <= win;
        end
        OWN: if (!m_cyc[gidx_q]) begin
          state_q <= IDLE;
          grant_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign own = (state_q == OWN);

  always_comb begin
    req_sel = '0;
    if (own) begin
      req_sel.we  = m_we[gidx_q];
      req_sel.adr = m_adr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
      req_sel.dat = m_dat_w[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      req_sel.sel = m_sel[gidx_q*SEL_WIDTH +: SEL_WIDTH];
    end
  end

  assign s_cyc   = own & m_cyc[gidx_q];
  assign s_stb   = own & m_stb[gidx_q];
  assign s_we    = req_sel.we;
  assign s_adr   = req_sel.adr;
  assign s_dat_w = req_sel.dat;
  assign s_sel   = req_sel.sel;
  assign m_dat_r = s_dat_r;
  assign grant   = grant_q;

  if (TIMEOUT > 0) begin : g_to
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] toc_q;
    logic          to_q;
    logic [7:0]    tcnt_q;
    logic          wait_c;
    logic          hit;

    // The err cycle itself never counts as waiting, so the count restarts after it.
    assign wait_c = s_stb & ~s_ack & ~s_err & ~to_q;
    assign hit    = wait_c & s_cyc & (toc_q == TW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        toc_q  <= '0;
        to_q   <= 1'b0;
        tcnt_q <= '0;
      end else begin
        to_q  <= hit;
        toc_q <= (wait_c && !hit) ? toc_q + 1'b1 : '0;
        if (hit && tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
      end
    end

    assign to_pend       = to_q;
    assign timeout_count = tcnt_q;
  end else begin : g_no_to
    assign to_pend       = 1'b0;
    assign timeout_count = '0;
  end

  assign timeout_pulse = to_pend;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
    wb_rr_arb_port u_port (
      .sel_i (grant_q[i]),
      .stb_i (m_stb[i]),
      .ack_i (s_ack),
      .err_i (s_err),
      .to_i  (to_pend),
      .ack_o (m_ack[i]),
      .err_o (m_err[i])
    );
  end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin Wishbone classic arbiter that shares one slave port among NUM_MASTERS masters, such as the management SoC bus and debug/DMA masters.
- Locks the grant for the whole cyc cycle of a master.
- Routes acknowledge and error responses back to the granted master only.
- Applies a bus timeout that terminates a transaction with err when the slave never responds.
- Sits between the masters and the existing single-slave ack state machine.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; select width SEL_WIDTH = DATA_WIDTH/8
TIMEOUT, 255, cycles of unanswered stb before err; 0 disables timeout

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset, asynchronous, active-high
m_cyc  in  NUM_MASTERS  per-master cyc
m_stb  in  NUM_MASTERS  per-master stb
m_we  in  NUM_MASTERS  per-master write enable
m_adr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_w  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_sel  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
m_ack  out  NUM_MASTERS  per-master ack
m_err  out  NUM_MASTERS  per-master err
m_dat_r  out  DATA_WIDTH  read data, shared by all masters (valid only with own ack)
s_cyc, s_stb, s_we  out  1  slave control
s_adr  out  ADDR_WIDTH  slave address
s_dat_w  out  DATA_WIDTH  slave write data
s_sel  out  SEL_WIDTH  slave byte select
s_ack, s_err  in  1  slave response
s_dat_r  in  DATA_WIDTH  slave read data
grant  out  NUM_MASTERS  one-hot registered grant
timeout_pulse  out  1  one-cycle pulse on a timeout
timeout_count  out  8  saturating count of timeouts since reset

Behaviour:
- Reset (async, sys_rst=1): state IDLE, grant=0, last=NUM_MASTERS-1 (master 0 has first priority), toc=0, timeout_count=0, timeout_pulse=0. All s_* controls are 0 and m_ack/m_err are 0 while reset is asserted. Reset in mid-transaction drops s_cyc/s_stb immediately; the master sees no ack.
- States: IDLE, OWN.
- IDLE: if any m_cyc=1, grant the first requester searching from last+1 modulo NUM_MASTERS. grant is registered at the clock edge, state goes to OWN and last is set to the winner. Arbitration latency is one cycle. s_cyc=s_stb=0 in IDLE.
- OWN, routing: routing is combinational from the granted index g.
  - s_cyc=m_cyc[g], s_stb=m_stb[g]; s_we, s_adr, s_dat_w and s_sel come from master g.
  - m_ack[g]=s_ack&m_stb[g], m_err[g]=s_err&m_stb[g]; all other m_ack/m_err bits are 0. m_dat_r=s_dat_r.
- OWN, release: when m_cyc[g]=0 at a clock edge, grant goes to 0 and state returns to IDLE. There is always one idle cycle between owners, so the same master cannot hold two consecutive grants while others are requesting.
- Timeout (TIMEOUT>0):
  - In OWN, toc increments each cycle with s_stb=1 & s_ack=0 & s_err=0, and clears otherwise.
  - When toc==TIMEOUT-1 and no response arrives, the next cycle drives m_err[g]=1 for exactly one cycle and masks s_ack/s_err. In that same cycle: timeout_pulse=1, toc clears, and timeout_count increments, saturating at 255.
  - If s_ack or s_err arrives in the same cycle that toc reaches the threshold, the slave response wins and no timeout occurs.
- Requests and response corner cases:
  - Simultaneous requests are resolved only by round-robin order; lower index has no fixed priority.
  - A master that drops m_cyc in IDLE before being granted is simply not considered.
  - s_ack while s_stb=0 is ignored and not forwarded.
  - In IDLE, s_ack/s_err are ignored.
- Timeout disabled (TIMEOUT=0): the counter logic is absent and timeout_pulse and timeout_count stay 0.

Test Plan:
- Single master: m_cyc[1]=m_stb[1]=1 at cycle 0, slave acks at cycle 3 -> grant=4'b0010 from cycle 1; s_adr=m_adr[1]; m_ack[1]=1 only in cycle 3; grant=0 one cycle after m_cyc[1] drops.
- Fairness: masters 0, 2 and 3 request continuously with immediate ack and one-cycle cyc each -> grant order is 0,2,3,0,2,3 with one IDLE cycle between grants; master 1 is never granted.
- Timeout with TIMEOUT=8: master 0 stb held and slave silent -> m_err[0]=1 exactly 8 cycles after s_stb rises; timeout_pulse=1 in that cycle; timeout_count=1.
- Race with TIMEOUT=8: s_ack arrives on the 8th waiting cycle -> m_ack[0]=1, m_err=0, timeout_count unchanged.
- Reset mid-transaction: assert sys_rst between edges while master 2 is owner -> s_cyc=0 and grant=0 immediately; after release, simultaneous requests from 2 and 3 grant master 2 first (master 0 has top priority, next search from index 0).
- Isolation: s_ack asserted while grant=4'b0100 -> m_ack=4'b0100; s_ack in IDLE -> m_ack=0.
